// File: rtl/cavlc_pkg.sv
// Shared types and constants for the CAVLC level encoder slice.
package cavlc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    T1SIGN = 2'd1,
    LEVEL  = 2'd2,
    DONE   = 2'd3
  } cavlc_state_e;

  localparam logic [4:0] ESC_PREFIX      = 5'd15;
  localparam logic [3:0] ESC_SUFFIX_BITS = 4'd12;
  localparam logic [2:0] MAX_SUFFIX_LEN  = 3'd6;
  localparam int         CW_W            = 28;

endpackage

// File: rtl/cavlc_level_vlc.sv
// Combinational level VLC: (levelCode, suffixLength) -> codeword, length, next suffixLength.
module cavlc_level_vlc #(
  parameter int CW_W = 28
) (
  input  logic [7:0]      lc,
  input  logic [7:0]      raw_lc,
  input  logic [2:0]      sl,
  output logic [CW_W-1:0] cw_data,
  output logic [4:0]      cw_len,
  output logic [2:0]      next_sl
);
  import cavlc_pkg::*;

  logic [4:0]  prefix_s;
  logic [3:0]  suf_len_s;
  logic [11:0] suffix_s;
  logic [15:0] esc_thr_s;
  logic [8:0]  abs_l_s;
  logic [8:0]  inc_thr_s;
  logic [2:0]  sl_base_s;

  // Prefix/suffix split, including the escape code
  always_comb begin
    prefix_s  = 5'd0;
    suf_len_s = 4'd0;
    suffix_s  = 12'd0;
    esc_thr_s = 16'(ESC_PREFIX) << sl;
    if (sl == 3'd0) begin
      if (lc < 8'd14) begin
        prefix_s = lc[4:0];
      end else if (lc < 8'd30) begin
        prefix_s  = 5'd14;
        suf_len_s = 4'd4;
        suffix_s  = 12'(lc - 8'd14);
      end else begin
        prefix_s  = ESC_PREFIX;
        suf_len_s = ESC_SUFFIX_BITS;
        suffix_s  = 12'(lc - 8'd30);
      end
    end else if ({8'd0, lc} < esc_thr_s) begin
      prefix_s  = 5'({8'd0, lc} >> sl);
      suf_len_s = {1'b0, sl};
      suffix_s  = 12'(lc & ((8'd1 << sl) - 8'd1));
    end else begin
      prefix_s  = ESC_PREFIX;
      suf_len_s = ESC_SUFFIX_BITS;
      suffix_s  = 12'({8'd0, lc} - esc_thr_s);
    end
  end

  // Leading zeros are implicit in the right-aligned value; only the marker 1 and suffix are stored
  assign cw_data = CW_W'((32'd1 << suf_len_s) | 32'(suffix_s));
  assign cw_len  = prefix_s + 5'd1 + 5'(suf_len_s);

  // Adaptive suffixLength update, driven by the unadjusted magnitude
  always_comb begin
    abs_l_s   = (9'(raw_lc) + 9'd2) >> 1;
    if (sl == 3'd0) begin
      sl_base_s = 3'd1;
    end else begin
      sl_base_s = sl;
    end
    inc_thr_s = 9'd3 << (sl_base_s - 3'd1);
    if ((abs_l_s > inc_thr_s) && (sl_base_s < MAX_SUFFIX_LEN)) begin
      next_sl = sl_base_s + 3'd1;
    end else begin
      next_sl = sl_base_s;
    end
  end

endmodule

// File: rtl/cavlc_level_encoder.sv
// CAVLC trailing-one sign and level codeword emitter with adaptive suffixLength.
// Optional macro CAVLC_LEVEL_BITCNT_EN adds the blk_bits per-block bit count output.
module cavlc_level_encoder #(
  parameter int CW_W       = 28,
  parameter int LIST_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cnt_valid,
  output logic                       cavlc_enc_ready,
  input  logic [4:0]                 total_coeff_cnt,
  input  logic [1:0]                 trailing_ones_cnt,
  input  logic [2:0]                 trailing_ones_flag,
  input  logic [LIST_DEPTH-1:0][7:0] level_code_list,
  input  logic [4:0]                 level_code_cnt,
  input  logic [9:0]                 topleft_x,
  input  logic [9:0]                 topleft_y,
  output logic                       cw_valid,
  input  logic                       cw_ready,
  output logic [CW_W-1:0]            cw_data,
  output logic [4:0]                 cw_len,
  output logic                       blk_done,
  output logic [9:0]                 topleft_x_o,
  output logic [9:0]                 topleft_y_o
`ifdef CAVLC_LEVEL_BITCNT_EN
  ,
  output logic [8:0]                 blk_bits
`endif
);
  import cavlc_pkg::*;

  localparam int IDX_W = (LIST_DEPTH > 1) ? $clog2(LIST_DEPTH) : 1;

  cavlc_state_e              state_r;
  logic [LIST_DEPTH-1:0][7:0] list_r;
  logic [1:0]                t1_r;
  logic [4:0]                lvl_cnt_r;
  logic [4:0]                idx_r;
  logic [2:0]                sl_r;

  logic [2:0]      sl_init_s;
  logic [2:0]      t1_code_s;
  logic [7:0]      raw_sel_s;
  logic [7:0]      lc_sel_s;
  logic [2:0]      sl_sel_s;
  logic            adj_s;
  logic [CW_W-1:0] vlc_data_s;
  logic [4:0]      vlc_len_s;
  logic [2:0]      vlc_next_sl_s;

  assign sl_init_s = ((total_coeff_cnt > 5'd10) && (trailing_ones_cnt != 2'd3)) ? 3'd1 : 3'd0;

  // Trailing-one signs, first one in encode order goes out first
  always_comb begin
    case (trailing_ones_cnt)
      2'd1:    t1_code_s = {2'b00, trailing_ones_flag[0]};
      2'd2:    t1_code_s = {1'b0, trailing_ones_flag[0], trailing_ones_flag[1]};
      2'd3:    t1_code_s = {trailing_ones_flag[0], trailing_ones_flag[1], trailing_ones_flag[2]};
      default: t1_code_s = 3'd0;
    endcase
  end

  // In IDLE the first level is coded straight from the inputs so it is ready one cycle after accept
  always_comb begin
    if (state_r == IDLE) begin
      raw_sel_s = level_code_list[0];
      adj_s     = (trailing_ones_cnt != 2'd3);
      sl_sel_s  = sl_init_s;
    end else begin
      raw_sel_s = list_r[idx_r[IDX_W-1:0]];
      adj_s     = (idx_r == 5'd0) && (t1_r != 2'd3);
      sl_sel_s  = sl_r;
    end
    if (adj_s) begin
      lc_sel_s = raw_sel_s - 8'd2;
    end else begin
      lc_sel_s = raw_sel_s;
    end
  end

  cavlc_level_vlc #(.CW_W(CW_W)) u_vlc (
    .lc      (lc_sel_s),
    .raw_lc  (raw_sel_s),
    .sl      (sl_sel_s),
    .cw_data (vlc_data_s),
    .cw_len  (vlc_len_s),
    .next_sl (vlc_next_sl_s)
  );

  // Block sequencing and registered codeword channel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r         <= IDLE;
      cavlc_enc_ready <= 1'b1;
      cw_valid        <= 1'b0;
      cw_data         <= '0;
      cw_len          <= 5'd0;
      blk_done        <= 1'b0;
      topleft_x_o     <= 10'd0;
      topleft_y_o     <= 10'd0;
      list_r          <= '0;
      t1_r            <= 2'd0;
      lvl_cnt_r       <= 5'd0;
      idx_r           <= 5'd0;
      sl_r            <= 3'd0;
    end else begin
      blk_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cnt_valid) begin
            cavlc_enc_ready <= 1'b0;
            list_r          <= level_code_list;
            t1_r            <= trailing_ones_cnt;
            lvl_cnt_r       <= level_code_cnt;
            topleft_x_o     <= topleft_x;
            topleft_y_o     <= topleft_y;
            idx_r           <= 5'd0;
            sl_r            <= sl_init_s;
            if (total_coeff_cnt == 5'd0) begin
              state_r  <= DONE;
              blk_done <= 1'b1;
            end else if (trailing_ones_cnt != 2'd0) begin
              state_r  <= T1SIGN;
              cw_valid <= 1'b1;
              cw_data  <= CW_W'(t1_code_s);
              cw_len   <= {3'd0, trailing_ones_cnt};
            end else if (level_code_cnt != 5'd0) begin
              state_r  <= LEVEL;
              cw_valid <= 1'b1;
              cw_data  <= vlc_data_s;
              cw_len   <= vlc_len_s;
              sl_r     <= vlc_next_sl_s;
              idx_r    <= 5'd1;
            end else begin
              state_r  <= DONE;
              blk_done <= 1'b1;
            end
          end
        end
        T1SIGN, LEVEL: begin
          if (cw_ready) begin
            if (idx_r == lvl_cnt_r) begin
              state_r  <= DONE;
              cw_valid <= 1'b0;
              blk_done <= 1'b1;
            end else begin
              state_r  <= LEVEL;
              cw_data  <= vlc_data_s;
              cw_len   <= vlc_len_s;
              sl_r     <= vlc_next_sl_s;
              idx_r    <= idx_r + 5'd1;
            end
          end
        end
        DONE: begin
          state_r         <= IDLE;
          cavlc_enc_ready <= 1'b1;
        end
        default: begin
          state_r         <= IDLE;
          cavlc_enc_ready <= 1'b1;
          cw_valid        <= 1'b0;
        end
      endcase
    end
  end

`ifdef CAVLC_LEVEL_BITCNT_EN
  logic [8:0] bits_r;

  // Running length of the accepted codewords of the current block
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bits_r <= 9'd0;
    end else if ((state_r == IDLE) && cnt_valid) begin
      bits_r <= 9'd0;
    end else if (cw_valid && cw_ready) begin
      bits_r <= bits_r + 9'(cw_len);
    end
  end

  assign blk_bits = bits_r;
`endif

endmodule

// File: tb/tb_cavlc_level_encoder.sv
// Scoreboard bench for cavlc_level_encoder: directed blocks, monitor pops expected codewords.
module tb_cavlc_level_encoder;

  typedef struct packed {
    logic [27:0] d;
    logic [4:0]  l;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cnt_valid = 1'b0;
  logic             cavlc_enc_ready;
  logic [4:0]       total_coeff_cnt = 5'd0;
  logic [1:0]       trailing_ones_cnt = 2'd0;
  logic [2:0]       trailing_ones_flag = 3'd0;
  logic [15:0][7:0] level_code_list = '0;
  logic [4:0]       level_code_cnt = 5'd0;
  logic [9:0]       topleft_x = 10'd0;
  logic [9:0]       topleft_y = 10'd0;
  logic             cw_valid;
  logic             cw_ready = 1'b1;
  logic [27:0]      cw_data;
  logic [4:0]       cw_len;
  logic             blk_done;
  logic [9:0]       topleft_x_o;
  logic [9:0]       topleft_y_o;
`ifdef CAVLC_LEVEL_BITCNT_EN
  logic [8:0]       blk_bits;
`endif

  cavlc_level_encoder #(.CW_W(28), .LIST_DEPTH(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .cnt_valid          (cnt_valid),
    .cavlc_enc_ready    (cavlc_enc_ready),
    .total_coeff_cnt    (total_coeff_cnt),
    .trailing_ones_cnt  (trailing_ones_cnt),
    .trailing_ones_flag (trailing_ones_flag),
    .level_code_list    (level_code_list),
    .level_code_cnt     (level_code_cnt),
    .topleft_x          (topleft_x),
    .topleft_y          (topleft_y),
    .cw_valid           (cw_valid),
    .cw_ready           (cw_ready),
    .cw_data            (cw_data),
    .cw_len             (cw_len),
    .blk_done           (blk_done),
    .topleft_x_o        (topleft_x_o),
    .topleft_y_o        (topleft_y_o)
`ifdef CAVLC_LEVEL_BITCNT_EN
    ,
    .blk_bits           (blk_bits)
`endif
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic push(input logic [4:0] l, input logic [27:0] d);
    exp_t e;
    e.d = d;
    e.l = l;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every handshake, checks hold stability and blk_done timing
  initial begin
    exp_t        e;
    bit          stall_q = 1'b0;
    bit          done_q  = 1'b0;
    logic [27:0] hold_d  = '0;
    logic [4:0]  hold_l  = '0;
    int          evt_cyc = 0;
    int          bits_acc = 0;
    forever begin
      @(negedge clk);
      if (rst && mon_en) begin
        if (stall_q) begin
          chk("hold_valid", {31'd0, cw_valid}, 32'd1);
          chk("hold_data", {4'd0, cw_data}, {4'd0, hold_d});
          chk("hold_len", {27'd0, cw_len}, {27'd0, hold_l});
        end
        if (done_q) chk("done_pulse", {31'd0, blk_done}, 32'd0);
        if (cnt_valid && cavlc_enc_ready) begin
          evt_cyc  = cyc;
          bits_acc = 0;
        end
        if (cw_valid && cw_ready) begin
          evt_cyc = cyc;
          if (exp_q.size() == 0) begin
            chk("unexpected_cw", {27'd0, cw_len}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("cw_len", {27'd0, cw_len}, {27'd0, e.l});
            chk("cw_data", {4'd0, cw_data}, {4'd0, e.d});
            bits_acc += int'(e.l);
          end
        end
        if (blk_done) begin
          chk("done_q_empty", exp_q.size(), 32'd0);
          chk("done_latency", cyc, evt_cyc + 1);
`ifdef CAVLC_LEVEL_BITCNT_EN
          chk("blk_bits", {23'd0, blk_bits}, bits_acc);
`endif
        end
        stall_q = cw_valid && !cw_ready;
        hold_d  = cw_data;
        hold_l  = cw_len;
        done_q  = blk_done;
      end else begin
        stall_q = 1'b0;
        done_q  = 1'b0;
      end
    end
  end

  task automatic run_blk(input logic [4:0] tc, input logic [1:0] t1, input logic [2:0] fl,
                         input logic [4:0] cnt, input logic [15:0][7:0] lst,
                         input bit has_cw, input bit stall_esc);
    int g;
    logic [9:0] x;
    logic [9:0] y;
    x = 10'(int'(tc) * 37 + 5);
    y = 10'(int'(cnt) * 11 + 900);
    g = 0;
    while (!cavlc_enc_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    chk("ready_before_issue", {31'd0, cavlc_enc_ready}, 32'd1);
    total_coeff_cnt    = tc;
    trailing_ones_cnt  = t1;
    trailing_ones_flag = fl;
    level_code_cnt     = cnt;
    level_code_list    = lst;
    topleft_x          = x;
    topleft_y          = y;
    cnt_valid          = 1'b1;
    @(posedge clk); #1;
    cnt_valid = 1'b0;
    chk("ready_after_accept", {31'd0, cavlc_enc_ready}, 32'd0);
    chk("first_valid", {31'd0, cw_valid}, {31'd0, has_cw});
    chk("topleft_x_o", {22'd0, topleft_x_o}, {22'd0, x});
    chk("topleft_y_o", {22'd0, topleft_y_o}, {22'd0, y});
    if (stall_esc) begin
      g = 0;
      while (!(cw_valid && cw_len == 5'd28) && g < 50) begin
        @(posedge clk); #1; g++;
      end
      chk("stall_found_esc", {27'd0, cw_len}, 32'd28);
      cw_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 cw_ready = 1'b1;
    end
    g = 0;
    while (!blk_done && g < 200) begin
      @(posedge clk); #1; g++;
    end
    chk("done_seen", {31'd0, blk_done}, 32'd1);
    @(posedge clk); #1;
    chk("ready_after_done", {31'd0, cavlc_enc_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0][7:0] lst;

    // Reset state
    #12;
    chk("rst_ready", {31'd0, cavlc_enc_ready}, 32'd1);
    chk("rst_valid", {31'd0, cw_valid}, 32'd0);
    chk("rst_done", {31'd0, blk_done}, 32'd0);
    chk("rst_len", {27'd0, cw_len}, 32'd0);
    chk("rst_data", {4'd0, cw_data}, 32'd0);
    chk("rst_x", {22'd0, topleft_x_o}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // T1 signs only: flag[0]=0, flag[1]=1 -> 01
    lst = '0;
    push(5'd2, 28'd1);
    run_blk(5'd2, 2'd2, 3'b010, 5'd0, lst, 1'b1, 1'b0);

    // T1=3 sign order: flag[0],flag[1],flag[2] = 0,1,1
    push(5'd3, 28'd3);
    run_blk(5'd3, 2'd3, 3'b110, 5'd0, lst, 1'b1, 1'b0);

    // Level +3, first-level adjust, sL=0
    lst[0] = 8'd4;
    push(5'd3, 28'd1);
    run_blk(5'd1, 2'd0, 3'b000, 5'd1, lst, 1'b1, 1'b0);

    // sL=0 prefix-14 range: raw 22 -> lc 20 -> 14 zeros, 1, suffix 0110
    lst = '0; lst[0] = 8'd22;
    push(5'd19, 28'd22);
    run_blk(5'd1, 2'd0, 3'b000, 5'd1, lst, 1'b1, 1'b0);

    // T1=1 then boundary lc=13 (raw 15 adjusted)
    lst = '0; lst[0] = 8'd15;
    push(5'd1, 28'd1);
    push(5'd14, 28'd1);
    run_blk(5'd2, 2'd1, 3'b001, 5'd1, lst, 1'b1, 1'b0);

    // TC=11: sL starts at 1 and climbs to the cap of 6
    lst = '0;
    lst[0] = 8'd6;   lst[1] = 8'd10;  lst[2] = 8'd3;   lst[3] = 8'd1;
    lst[4] = 8'd20;  lst[5] = 8'd0;   lst[6] = 8'd40;  lst[7] = 8'd100;
    lst[8] = 8'd255; lst[9] = 8'd200; lst[10] = 8'd7;
    push(5'd4, 28'd2);   push(5'd5, 28'd6);   push(5'd3, 28'd7);   push(5'd3, 28'd5);
    push(5'd8, 28'd4);   push(5'd4, 28'd8);   push(5'd9, 28'd8);   push(5'd11, 28'd20);
    push(5'd13, 28'd63); push(5'd10, 28'd72); push(5'd7, 28'd71);
    run_blk(5'd11, 2'd0, 3'b000, 5'd11, lst, 1'b1, 1'b0);

    // T1=3, escape at sL=0 (prefix 15, suffix 10)
    lst = '0; lst[0] = 8'd40;
    push(5'd3, 28'd0);
    push(5'd28, 28'd4106);
    run_blk(5'd4, 2'd3, 3'b000, 5'd1, lst, 1'b1, 1'b0);

    // Same block, escape codeword stalled 3 cycles
    push(5'd3, 28'd0);
    push(5'd28, 28'd4106);
    run_blk(5'd4, 2'd3, 3'b000, 5'd1, lst, 1'b1, 1'b1);

    // Escape at sL=1 on the second level: lc 34 - 30 = 4
    lst = '0; lst[0] = 8'd4; lst[1] = 8'd34;
    push(5'd3, 28'd1);
    push(5'd28, 28'd4100);
    run_blk(5'd2, 2'd0, 3'b000, 5'd2, lst, 1'b1, 1'b0);

    // Empty block
    lst = '0;
    run_blk(5'd0, 2'd0, 3'b000, 5'd0, lst, 1'b0, 1'b0);

    // Reset in the middle of LEVEL abandons the block
    mon_en = 1'b0;
    cw_ready = 1'b0;
    lst = '0; lst[0] = 8'd6; lst[1] = 8'd10; lst[2] = 8'd3;
    total_coeff_cnt = 5'd11; trailing_ones_cnt = 2'd0; level_code_cnt = 5'd11;
    level_code_list = lst;
    cnt_valid = 1'b1;
    @(posedge clk); #1 cnt_valid = 1'b0;
    @(posedge clk); #1;
    chk("midblk_valid", {31'd0, cw_valid}, 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, cw_valid}, 32'd0);
    chk("midrst_ready", {31'd0, cavlc_enc_ready}, 32'd1);
    chk("midrst_len", {27'd0, cw_len}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    cw_ready = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Normal block after the reset
    lst = '0; lst[0] = 8'd4;
    push(5'd3, 28'd1);
    run_blk(5'd1, 2'd0, 3'b000, 5'd1, lst, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    chk("final_q_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
